pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 32, PC/address width; RESET_VECTOR, 0, pc_o value under reset; RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2); INSTR_BYTES, 4, sequential increment (power of 2).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-low.
- stall_i, in, 1, hold fetch PC.
- flush_i, in, 1, trap/exception redirect.
- flush_pc_i, in, WIDTH, flush target.
- branch_taken_i, in, 1, late-stage branch redirect.
- branch_target_i, in, WIDTH, branch target.
- call_i, in, 1, fetch-stage call predecode.
- ret_i, in, 1, fetch-stage return predecode.
- jump_target_i, in, WIDTH, call target.
- pc_o, out, WIDTH, current fetch PC (registered).
- pc_valid_o, out, 1, pc_o is fetchable.
- ras_empty_o, out, 1, RAS holds 0 entries.
- ras_full_o, out, 1, RAS holds RAS_DEPTH entries.
- misaligned_o, out, 1, pc_o low bits nonzero (macro-dependent, REQ-019).

Function
REQ-003 pc_o SHALL update only on posedge clk; next-PC selection priority: flush_i > branch_taken_i > stall_i (hold) > ret_i/call_i > sequential.
REQ-004 flush_i SHALL load flush_pc_i and empty the RAS (count=0) regardless of all other inputs, including stall_i.
REQ-005 branch_taken_i without flush_i SHALL load branch_target_i regardless of stall_i; RAS unchanged; call_i/ret_i ignored that cycle.
REQ-006 stall_i without flush_i/branch_taken_i SHALL hold pc_o and leave the RAS unchanged; call_i/ret_i ignored.
REQ-007 call_i alone SHALL push pc_o+INSTR_BYTES and load jump_target_i.
REQ-008 ret_i alone with RAS non-empty SHALL pop and load the popped entry; with RAS empty SHALL load pc_o+INSTR_BYTES, RAS unchanged.
REQ-009 call_i and ret_i together SHALL replace the top entry with pc_o+INSTR_BYTES (pure push if empty) and load jump_target_i; count unchanged unless empty.
REQ-010 Push on full RAS SHALL overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
REQ-011 No other event: pc_o <= pc_o+INSTR_BYTES.
REQ-012 All PC arithmetic SHALL be modulo 2^WIDTH (wrap from all-ones region to low addresses silently).
REQ-013 RAS pointer SHALL wrap modulo RAS_DEPTH; ras_empty_o/ras_full_o derive from registered count, updated the cycle after push/pop.
REQ-014 Latency: every redirect visible on pc_o exactly one clk after the sampling edge.

Reset
REQ-015 rst low SHALL immediately force pc_o=RESET_VECTOR, pc_valid_o=0, RAS count=0 (ras_empty_o=1, ras_full_o=0), misaligned_o=0.
REQ-016 After rst rises, the first posedge SHALL set pc_valid_o=1 and hold pc_o=RESET_VECTOR; sequential advance starts on the second posedge.
REQ-017 rst asserted mid-operation SHALL discard all pending redirects and RAS contents; RAS entry storage need not be cleared.

Configuration
REQ-018 Macro PC_ALIGN_CHECK_EN selects alignment handling.
REQ-019 Defined: targets loaded unmodified; misaligned_o=1 whenever pc_o[log2(INSTR_BYTES)-1:0]!=0. Undefined: low log2(INSTR_BYTES) bits of every loaded target forced to 0; misaligned_o tied 0.

Verification
REQ-020 Reset release, 3 idle clks, RESET_VECTOR=0x100 -> pc_o 0x100,0x100,0x104,0x108; pc_valid_o 0 then 1.
REQ-021 pc_o=0x200, call_i, jump_target_i=0x800; next clk ret_i -> pc_o 0x800 then 0x204; ras_empty_o back to 1.
REQ-022 RAS_DEPTH=4, 5 calls from 0x0,0x10,0x20,0x30,0x40, then 5 rets -> returns 0x44,0x34,0x24,0x14, then sequential; ras_full_o 1 after 4th call.
REQ-023 stall_i=1 with branch_taken_i=1, target 0x40, and flush_i=1, flush_pc_i=0x80 same cycle -> pc_o=0x80, ras_empty_o=1.
REQ-024 WIDTH=32, pc_o=0xFFFFFFFC idle -> pc_o=0x0.
REQ-025 branch_target_i=0x102, INSTR_BYTES=4 -> with PC_ALIGN_CHECK_EN pc_o=0x102, misaligned_o=1; without, pc_o=0x100, misaligned_o=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with redirect priority and a circular return-address stack
// Ports: clk, rst (async, active-low); stall_i, flush_i/flush_pc_i, branch_taken_i/branch_target_i,
//        call_i, ret_i, jump_target_i in; pc_o, pc_valid_o, ras_empty_o, ras_full_o, misaligned_o out.
// Build option PC_ALIGN_CHECK_EN: keep loaded targets unmodified and flag misaligned pc_o;
//        when undefined, targets are force-aligned to INSTR_BYTES and misaligned_o is tied 0.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4,
  parameter int INSTR_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] flush_pc_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] jump_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             misaligned_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] LOW = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [WIDTH-1:0] pc_q, pc_n, seq, wr_data;
  logic [PW-1:0] sp, sp_n, wr_idx;
  logic [PW:0] cnt, cnt_n;
  logic valid_q, wr_en, empty;
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] x);
`ifdef PC_ALIGN_CHECK_EN
    return x;
`else
    return x & ~LOW;
`endif
  endfunction
  assign seq = pc_q + STEP;
  assign empty = cnt == '0;
  assign wr_data = seq;
  // sp indexes the top entry; a push writes one above it, so a full stack overwrites the oldest
  always_comb begin
    pc_n = seq;
    sp_n = sp;
    cnt_n = cnt;
    wr_en = 1'b0;
    wr_idx = sp;
    if (!valid_q) pc_n = pc_q;
    else if (flush_i) begin
      pc_n = align(flush_pc_i);
      cnt_n = '0;
    end
    else if (branch_taken_i) pc_n = align(branch_target_i);
    else if (stall_i) pc_n = pc_q;
    else if (call_i && ret_i && !empty) begin
      pc_n = align(jump_target_i);
      wr_en = 1'b1;
    end
    else if (call_i) begin
      pc_n = align(jump_target_i);
      wr_en = 1'b1;
      wr_idx = sp + 1'b1;
      sp_n = sp + 1'b1;
      cnt_n = cnt == FULL ? cnt : cnt + 1'b1;
    end
    else if (ret_i && !empty) begin
      pc_n = ras[sp];
      sp_n = sp - 1'b1;
      cnt_n = cnt - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q <= RESET_VECTOR;
      valid_q <= 1'b0;
      sp <= '0;
      cnt <= '0;
    end else begin
      pc_q <= pc_n;
      valid_q <= 1'b1;
      sp <= sp_n;
      cnt <= cnt_n;
    end
  always_ff @(posedge clk)
    if (wr_en) ras[wr_idx] <= wr_data;
`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) mis_q <= 1'b0;
    else mis_q <= |(pc_n & LOW);
  assign misaligned_o = mis_q;
`else
  assign misaligned_o = 1'b0;
`endif
  assign pc_o = pc_q;
  assign pc_valid_o = valid_q;
  assign ras_empty_o = empty;
  assign ras_full_o = cnt == FULL;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus randomized run against a queue-based reference model
module tb_pc_unit;
  logic clk = 0, rst = 0;
  logic stall_i = 0, flush_i = 0, branch_taken_i = 0, call_i = 0, ret_i = 0;
  logic [31:0] flush_pc_i = 0, branch_target_i = 0, jump_target_i = 0;
  logic [31:0] pc_o;
  logic pc_valid_o, ras_empty_o, ras_full_o, misaligned_o;
  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(4), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i), .call_i(call_i),
    .ret_i(ret_i), .jump_target_i(jump_target_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .misaligned_o(misaligned_o));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [31:0] m_pc = 32'h100;
  logic m_valid = 0;
  logic [31:0] m_ras[$];
  typedef struct {
    logic s, f, b, c, r;
    logic [31:0] fpc, bt, jt, exp_pc;
    logic exp_empty, exp_full, exp_mis;
  } vec_t;
  vec_t v[$];
  function automatic logic [31:0] al(input logic [31:0] x);
`ifdef PC_ALIGN_CHECK_EN
    return x;
`else
    return x & ~32'h3;
`endif
  endfunction
  function automatic logic m_mis();
`ifdef PC_ALIGN_CHECK_EN
    return m_valid && (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".valid"}, {31'b0, pc_valid_o}, {31'b0, m_valid});
    chk({tag, ".empty"}, {31'b0, ras_empty_o}, {31'b0, m_ras.size() == 0});
    chk({tag, ".full"}, {31'b0, ras_full_o}, {31'b0, m_ras.size() == 4});
    chk({tag, ".mis"}, {31'b0, misaligned_o}, {31'b0, m_mis()});
  endtask
  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (!m_valid) m_valid = 1;
    else if (flush_i) begin
      m_pc = al(flush_pc_i);
      m_ras.delete();
    end
    else if (branch_taken_i) m_pc = al(branch_target_i);
    else if (stall_i) m_pc = m_pc;
    else if (call_i) begin
      if (ret_i && m_ras.size() > 0) m_ras[m_ras.size() - 1] = seq;
      else begin
        m_ras.push_back(seq);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = al(jump_target_i);
    end
    else if (ret_i) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = seq;
    end
    else m_pc = seq;
  endtask
  task automatic drive(input logic s, f, b, c, r, input logic [31:0] fpc, bt, jt);
    stall_i = s; flush_i = f; branch_taken_i = b; call_i = c; ret_i = r;
    flush_pc_i = fpc; branch_target_i = bt; jump_target_i = jt;
  endtask
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask
  function automatic void add(input logic s, f, b, c, r, input logic [31:0] fpc, bt, jt, ep,
                              input logic ee, ef, em);
    vec_t x;
    x.s = s; x.f = f; x.b = b; x.c = c; x.r = r;
    x.fpc = fpc; x.bt = bt; x.jt = jt; x.exp_pc = ep;
    x.exp_empty = ee; x.exp_full = ef; x.exp_mis = em;
    v.push_back(x);
  endfunction
  initial begin
    logic [31:0] a_pc0, a_pc1;
    logic a_mis;
`ifdef PC_ALIGN_CHECK_EN
    a_pc0 = 32'h102; a_pc1 = 32'h106; a_mis = 1;
`else
    a_pc0 = 32'h100; a_pc1 = 32'h104; a_mis = 0;
`endif
    add(0,0,0,0,0, 0,0,0, 32'h100, 1,0,0);
    add(0,0,0,0,0, 0,0,0, 32'h104, 1,0,0);
    add(0,0,0,0,0, 0,0,0, 32'h108, 1,0,0);
    add(0,0,1,0,0, 0,32'h200,0, 32'h200, 1,0,0);
    add(0,0,0,1,0, 0,0,32'h800, 32'h800, 0,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h204, 1,0,0);
    add(0,0,1,0,0, 0,32'h0,0, 32'h0, 1,0,0);
    add(0,0,0,1,0, 0,0,32'h10, 32'h10, 0,0,0);
    add(0,0,0,1,0, 0,0,32'h20, 32'h20, 0,0,0);
    add(0,0,0,1,0, 0,0,32'h30, 32'h30, 0,0,0);
    add(0,0,0,1,0, 0,0,32'h40, 32'h40, 0,1,0);
    add(0,0,0,1,0, 0,0,32'h50, 32'h50, 0,1,0);
    add(0,0,0,0,1, 0,0,0, 32'h44, 0,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h34, 0,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h24, 0,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h14, 1,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h18, 1,0,0);
    add(0,0,0,1,0, 0,0,32'h300, 32'h300, 0,0,0);
    add(1,1,1,0,0, 32'h80,32'h40,0, 32'h80, 1,0,0);
    add(1,0,0,0,0, 0,0,0, 32'h80, 1,0,0);
    add(1,0,0,1,0, 0,0,32'h900, 32'h80, 1,0,0);
    add(0,0,1,1,0, 0,32'h1000,32'h2000, 32'h1000, 1,0,0);
    add(0,0,1,0,0, 0,32'hFFFFFFFC,0, 32'hFFFFFFFC, 1,0,0);
    add(0,0,0,0,0, 0,0,0, 32'h0, 1,0,0);
    add(0,0,1,0,0, 0,32'hFFFFFFFC,0, 32'hFFFFFFFC, 1,0,0);
    add(0,0,0,1,0, 0,0,32'h40, 32'h40, 0,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h0, 1,0,0);
    add(0,0,0,1,1, 0,0,32'h500, 32'h500, 0,0,0);
    add(0,0,0,1,1, 0,0,32'h600, 32'h600, 0,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h504, 1,0,0);
    add(0,0,0,0,1, 0,0,0, 32'h508, 1,0,0);
    add(0,0,1,0,0, 0,32'h102,0, a_pc0, 1,0,a_mis);
    add(0,0,0,0,0, 0,0,0, a_pc1, 1,0,a_mis);
    #12;
    chk_model("reset");
    chk("reset_pc", pc_o, 32'h100);
    @(negedge clk);
    rst = 1;
    foreach (v[i]) begin
      drive(v[i].s, v[i].f, v[i].b, v[i].c, v[i].r, v[i].fpc, v[i].bt, v[i].jt);
      cyc($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.exp_pc", i), pc_o, v[i].exp_pc);
      chk($sformatf("vec%0d.exp_empty", i), {31'b0, ras_empty_o}, {31'b0, v[i].exp_empty});
      chk($sformatf("vec%0d.exp_full", i), {31'b0, ras_full_o}, {31'b0, v[i].exp_full});
      chk($sformatf("vec%0d.exp_mis", i), {31'b0, misaligned_o}, {31'b0, v[i].exp_mis});
      if (i == 0) chk("valid_up", {31'b0, pc_valid_o}, 32'd1);
    end
    drive(0,0,0,1,0, 0,0,32'h700);
    cyc("pre_rst_call");
    drive(0,0,1,0,0, 0,32'h900,0);
    #3 rst = 0;
    #1;
    m_pc = 32'h100; m_valid = 0; m_ras.delete();
    chk_model("mid_rst");
    @(negedge clk);
    rst = 1;
    drive(0,0,0,0,0, 0,0,0);
    cyc("rst_hold");
    chk("rst_hold_pc", pc_o, 32'h100);
    cyc("rst_adv");
    chk("rst_adv_pc", pc_o, 32'h104);
    drive(0,0,0,0,1, 0,0,0);
    cyc("rst_ret_empty");
    chk("rst_ret_empty_pc", pc_o, 32'h108);
    repeat (3000) begin
      drive($urandom_range(5) == 0, $urandom_range(31) == 0, $urandom_range(7) == 0,
            $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom, $urandom, ($urandom_range(1) == 0) ? ($urandom & ~32'h3) : $urandom);
      cyc("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
